// File: rtl/keypad_emu_pkg.sv
// Shared types and constants for the 4x4 matrix keypad emulator.
package keypad_emu_pkg;

    // Press lifecycle: accept, wait for the scanner to strobe our column,
    // hold the contact closed, then force a release gap.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_COL = 2'd1,
        ST_PRESS    = 2'd2,
        ST_GAP      = 2'd3
    } state_e;

    // Key indices as laid out on the calculator keypad (row = idx/4, col = idx%4).
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_ADD  = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_SUB  = 4'd7;
    localparam logic [3:0] KEY_7    = 4'd8;
    localparam logic [3:0] KEY_MULT = 4'd11;
    localparam logic [3:0] KEY_EQ   = 4'd12;
    localparam logic [3:0] KEY_NEG  = 4'd15;

    // Row lines are active-low; nothing pressed reads as all ones.
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] idx);
        return idx[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] idx);
        return idx[1:0];
    endfunction

    // Used to size the shared phase counter from the three durations.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_emu_timer.sv
// Loadable, saturating up-counter with terminal-count compare. One instance
// times the column wait, the hold and the release gap in turn.
module keypad_emu_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         nRST,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise step up and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == term);

endmodule

// File: rtl/keypad_emulator.sv
// Synthesizable 4x4 matrix keypad model answering a column-strobing scanner.
// Optional contact bounce at both edges of a press: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
    import keypad_emu_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BOUNCE_LEN     = 4
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] ColOut,
    output logic [3:0] RowIn,
    input  logic       key_valid,
    input  logic [3:0] key_idx,
    output logic       key_ready,
    output logic       busy,
    output logic       press_done,
    output logic       timeout_err
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] TERM_WAIT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_PRESS = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_GAP   = CNT_W'(GAP_CYCLES - 1);

    // Reject parameter sets for which the phases would be empty or the bounce
    // window would swallow a whole phase.
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        BOUNCE_LEN >= HOLD_CYCLES || BOUNCE_LEN >= GAP_CYCLES) begin : g_bad_params
        $error("keypad_emulator: illegal HOLD/GAP/TIMEOUT/BOUNCE_LEN combination");
    end

    state_e           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic             press_done_q, press_done_d;
    logic             timeout_err_q, timeout_err_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             col_match;
    logic             contact_closed;

    keypad_emu_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .nRST  (nRST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term),
        .count (cnt),
        .tc    (cnt_tc)
    );

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_W = CNT_W'(BOUNCE_LEN);
`else
    // Clean edges never look at the phase position, only at its end.
    logic cnt_unused;
    assign cnt_unused = ^cnt;
`endif

    // Only the exact one-cold strobe of our column counts as being scanned.
    assign col_match = (ColOut == ~(4'b0001 << col_q));

    // Next-state, counter control and contact state for the press lifecycle.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        press_done_d   = 1'b0;
        timeout_err_d  = 1'b0;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        cnt_term       = '0;
        contact_closed = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    row_d   = key_row(key_idx);
                    col_d   = key_col(key_idx);
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT_COL;
                end
            end

            ST_WAIT_COL: begin
                cnt_term = TERM_WAIT;
                if (col_match) begin
                    cnt_clr = 1'b1;
                    state_d = ST_PRESS;
                end else if (cnt_tc) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_PRESS: begin
                cnt_term = TERM_PRESS;
`ifdef KEYPAD_EMU_BOUNCE_EN
                // Chatter on make: closed on even cycles of the bounce window.
                contact_closed = (cnt >= BOUNCE_W) || !cnt[0];
`else
                contact_closed = 1'b1;
`endif
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            ST_GAP: begin
                cnt_term = TERM_GAP;
`ifdef KEYPAD_EMU_BOUNCE_EN
                // Chatter on break: closed on odd cycles of the bounce window.
                contact_closed = (cnt < BOUNCE_W) && cnt[0];
`else
                contact_closed = 1'b0;
`endif
                if (cnt_tc) begin
                    cnt_clr      = 1'b1;
                    press_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched key and status pulse registers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            col_q         <= '0;
            press_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            press_done_q  <= press_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Zero-delay switch: the row follows our column strobe combinationally,
    // so a scanner that has moved on sees the row released.
    always_comb begin
        RowIn = ROW_IDLE;
        if (contact_closed && !ColOut[col_q]) begin
            RowIn = ~(4'b0001 << row_q);
        end
    end

    assign key_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign press_done  = press_done_q;
    assign timeout_err = timeout_err_q;

endmodule
